// File: rtl/reg_file_ctx_pkg.sv
// rtl/reg_file_ctx_pkg.sv - shared types and sizing helpers for the context register file
package reg_file_ctx_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SAVE,
    RESTORE
  } ctx_state_t;

  // Words per context frame: every general register plus the jump register.
  function automatic int frame_size(input int a);
    return (1 << a) + 1;
  endfunction

  function automatic int depth_width(input int d);
    return $clog2(d + 1);
  endfunction

endpackage

// File: rtl/reg_file_ctx_stack.sv
// rtl/reg_file_ctx_stack.sv - ctx_stack: D frames of F words, one sync write port, one comb read port
module ctx_stack #(
  parameter int W  = 8,
  parameter int D  = 4,
  parameter int F  = 5,
  parameter int FW = 2,
  parameter int IW = 3
) (
  input  logic          clk,
  input  logic          we,
  input  logic [FW-1:0] wr_frame,
  input  logic [IW-1:0] wr_idx,
  input  logic [W-1:0]  wr_data,
  input  logic [FW-1:0] rd_frame,
  input  logic [IW-1:0] rd_idx,
  output logic [W-1:0]  rd_data
);

  localparam int AW = (D * F > 1) ? $clog2(D * F) : 1;

  logic [W-1:0]  mem [D*F];
  logic [AW-1:0] wr_addr;
  logic [AW-1:0] rd_addr;

  // Frames are laid out back to back; contents deliberately survive reset.
  assign wr_addr = AW'(wr_frame) * AW'(F) + AW'(wr_idx);
  assign rd_addr = AW'(rd_frame) * AW'(F) + AW'(rd_idx);
  assign rd_data = mem[rd_addr];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[wr_addr] <= wr_data;
    end
  end

endmodule

// File: rtl/reg_file_ctx.sv
// rtl/reg_file_ctx.sv - register file with serial context save/restore stack; REG_FILE_CTX_BYPASS_EN adds write-to-read forwarding
module reg_file_ctx
  import reg_file_ctx_pkg::*;
#(
  parameter int W = 8,
  parameter int A = 2,
  parameter int D = 4
) (
  input  logic                           Clk,
  input  logic                           Reset,
  input  logic                           WriteEn,
  input  logic                           LutWrEn,
  input  logic                           JumpWrEn,
  input  logic [A-1:0]                   Waddr,
  input  logic [W-1:0]                   DataIn,
  input  logic [W-1:0]                   LutData,
  input  logic                           SetInst,
  input  logic [A-1:0]                   RaddrA,
  input  logic [A-1:0]                   RaddrB,
  output logic [W-1:0]                   DataOutA,
  output logic [W-1:0]                   DataOutB,
  output logic [W-1:0]                   JumpReg,
  input  logic                           CtxSave,
  input  logic                           CtxRestore,
  output logic                           Busy,
  output logic [depth_width(D)-1:0]      CtxDepth,
  output logic                           CtxErr
);

  localparam int N  = 1 << A;
  localparam int F  = frame_size(A);
  localparam int DW = depth_width(D);
  localparam int IW = $clog2(F);
  localparam int FW = (D > 1) ? $clog2(D) : 1;

  logic [W-1:0]  regs [N];
  logic [W-1:0]  jump_q;
  ctx_state_t    state, state_next;
  logic [IW-1:0] idx, idx_next;
  logic [DW-1:0] depth, depth_next;
  logic          err_q, err_next;
  logic          last;
  logic          stk_we;
  logic [FW-1:0] wr_frame, rd_frame;
  logic [W-1:0]  stk_wdata, stk_rdata;

  assign last      = (idx == IW'(F - 1));
  assign wr_frame  = FW'(depth);
  assign rd_frame  = FW'(depth - DW'(1));
  assign stk_wdata = (idx < IW'(N)) ? regs[idx[A-1:0]] : jump_q;

  ctx_stack #(
    .W (W),
    .D (D),
    .F (F),
    .FW(FW),
    .IW(IW)
  ) u_stack (
    .clk     (Clk),
    .we      (stk_we),
    .wr_frame(wr_frame),
    .wr_idx  (idx),
    .wr_data (stk_wdata),
    .rd_frame(rd_frame),
    .rd_idx  (idx),
    .rd_data (stk_rdata)
  );

  always_comb begin
    state_next = state;
    idx_next   = idx;
    depth_next = depth;
    err_next   = 1'b0;
    stk_we     = 1'b0;
    case (state)
      IDLE: begin
        idx_next = '0;
        if (CtxSave && CtxRestore) begin
          err_next = 1'b1;
        end else if (CtxSave) begin
          if (depth < DW'(D)) state_next = SAVE;
          else                err_next   = 1'b1;
        end else if (CtxRestore) begin
          if (depth != '0) state_next = RESTORE;
          else             err_next   = 1'b1;
        end
      end
      SAVE: begin
        stk_we   = 1'b1;
        idx_next = idx + IW'(1);
        if (last) begin
          idx_next   = '0;
          depth_next = depth + DW'(1);
          state_next = IDLE;
        end
      end
      RESTORE: begin
        idx_next = idx + IW'(1);
        if (last) begin
          idx_next   = '0;
          depth_next = depth - DW'(1);
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < N; i++) regs[i] <= '0;
      jump_q <= '0;
      state  <= IDLE;
      idx    <= '0;
      depth  <= '0;
      err_q  <= 1'b0;
    end else begin
      state <= state_next;
      idx   <= idx_next;
      depth <= depth_next;
      err_q <= err_next;
      if (state == IDLE) begin
        if (WriteEn)      regs[Waddr] <= DataIn;
        else if (LutWrEn) regs[Waddr] <= LutData;
        if (JumpWrEn)     jump_q      <= DataIn;
      end else if (state == RESTORE) begin
        if (last) jump_q               <= stk_rdata;
        else      regs[idx[A-1:0]]     <= stk_rdata;
      end
    end
  end

`ifdef REG_FILE_CTX_BYPASS_EN
  logic         wr_act;
  logic [W-1:0] wr_data;
  logic [A-1:0] addr_a;

  // Forwarding only applies in IDLE, where the write will actually land.
  always_comb begin
    wr_act  = (state == IDLE) && (WriteEn || LutWrEn);
    wr_data = WriteEn ? DataIn : LutData;
    addr_a  = SetInst ? {A{1'b0}} : RaddrA;
    DataOutA = (wr_act && addr_a == Waddr) ? wr_data : regs[addr_a];
    DataOutB = (wr_act && RaddrB == Waddr) ? wr_data : regs[RaddrB];
    JumpReg  = (state == IDLE && JumpWrEn) ? DataIn : jump_q;
  end
`else
  assign DataOutA = regs[SetInst ? {A{1'b0}} : RaddrA];
  assign DataOutB = regs[RaddrB];
  assign JumpReg  = jump_q;
`endif

  assign Busy     = (state != IDLE);
  assign CtxDepth = depth;
  assign CtxErr   = err_q;

endmodule
